mul_08bitx08_wallace_seq: RTL and testbench

Sequential 8x8 unsigned multiplier that time-shares a single `mul_01bitx08_wallace` column compressor across all 16 product columns, one column per clock. Each cycle it gathers the partial-product bits of the current column and feeds them to the compressor together with the registered 6-bit carry vector from the previous column. It then folds the compressor's sum and carry outputs into a 1-bit ripple final adder. It sits between a valid/ready producer and consumer, trading area for a fixed 16-cycle latency.

---
 rtl/mul_08bitx08_wallace_seq.sv | 192 +++++++++++++++++++
 tb/tb_mul_08bitx08_wallace_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mul_08bitx08_wallace_seq.sv
// ---------------------------------------------------------------------------
// mul_08bitx08_wallace_seq
//
// Purpose: 8x8 unsigned multiplier. One column compressor is shared across
// all 16 product columns, one column per clock. Each cycle the compressor's
// sum and next-column carry are folded into a 1-bit ripple final adder. The
// latency from operand accept to o_valid is a fixed 16 cycles.
//
// Ports:
//   i_clk    in   1   clock, rising edge
//   i_rst    in   1   asynchronous active-high reset
//   i_valid  in   1   operand pair valid
//   o_ready  out  1   operands can be accepted (IDLE)
//   i_num_a  in   8   multiplicand, unsigned
//   i_num_b  in   8   multiplier, unsigned
//   o_valid  out  1   product valid (DONE)
//   i_ready  in   1   consumer accepts product
//   o_res    out  16  product a*b (registered)
//   o_busy   out  1   columns being processed (RUN)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// mul_01bitx08_wallace
//
// Purpose: compresses one product column of weight k. The inputs are up to 8
// partial-product bits and the 6 carries from the previous column's full
// adders. It produces one bit of weight k (o_res) and seven bits of weight
// k+1 (six full-adder carries plus one half-adder carry).
//
// Ports:
//   i_num        in   8  partial-product bits of this column
//   i_cry_06bit  in   6  full-adder carries from the previous column
//   o_res        out  1  column sum bit (weight k)
//   o_cry        out  1  half-adder carry (weight k+1)
//   o_cry_06bit  out  6  full-adder carries (weight k+1)
// ---------------------------------------------------------------------------
module mul_01bitx08_wallace (
  input  logic [7:0] i_num,
  input  logic [5:0] i_cry_06bit,
  output logic       o_res,
  output logic       o_cry,
  output logic [5:0] o_cry_06bit
);

  // Layer 1: three full adders over the raw bits. The earliest carry-in
  // joins the two leftover partial-product bits.
  logic s0, s1, s2;
  assign s0             = i_num[0] ^ i_num[1] ^ i_num[2];
  assign o_cry_06bit[0] = (i_num[0] & i_num[1]) | (i_num[0] & i_num[2]) | (i_num[1] & i_num[2]);
  assign s1             = i_num[3] ^ i_num[4] ^ i_num[5];
  assign o_cry_06bit[1] = (i_num[3] & i_num[4]) | (i_num[3] & i_num[5]) | (i_num[4] & i_num[5]);
  assign s2             = i_num[6] ^ i_num[7] ^ i_cry_06bit[0];
  assign o_cry_06bit[2] = (i_num[6] & i_num[7]) | (i_num[6] & i_cry_06bit[0]) | (i_num[7] & i_cry_06bit[0]);

  // Layer 2: merge the layer-1 sums. A second adder absorbs three carry-ins.
  logic s3, s4;
  assign s3             = s0 ^ s1 ^ s2;
  assign o_cry_06bit[3] = (s0 & s1) | (s0 & s2) | (s1 & s2);
  assign s4             = i_cry_06bit[1] ^ i_cry_06bit[2] ^ i_cry_06bit[3];
  assign o_cry_06bit[4] = (i_cry_06bit[1] & i_cry_06bit[2]) | (i_cry_06bit[1] & i_cry_06bit[3]) |
                          (i_cry_06bit[2] & i_cry_06bit[3]);

  // Layer 3: one full adder over the two layer-2 sums and carry-in 4.
  logic s5;
  assign s5             = s3 ^ s4 ^ i_cry_06bit[4];
  assign o_cry_06bit[5] = (s3 & s4) | (s3 & i_cry_06bit[4]) | (s4 & i_cry_06bit[4]);

  // Two weight-k bits remain. A half adder reduces them to one bit plus a
  // carry into the next column.
  assign o_res = s5 ^ i_cry_06bit[5];
  assign o_cry = s5 & i_cry_06bit[5];

endmodule

module mul_08bitx08_wallace_seq (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [7:0]  i_num_a,
  input  logic [7:0]  i_num_b,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_res,
  output logic        o_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [3:0]  r_col;
  logic [5:0]  r_cry6;
  logic        r_cry1;
  logic        r_cp;
  logic [15:0] r_res;

  // Gather the partial products of column r_col, packed from LSB upwards.
  // Multiplier rows i in the column start at row_lo. Columns above 7 lose
  // their low rows. Slot gi holds pp[row_lo+gi][r_col-row_lo-gi] when that
  // row/column pair exists, and 0 otherwise.
  logic [3:0] row_lo;
  logic [7:0] col_bits;
  logic [3:0] row_idx [8];
  logic [3:0] col_idx [8];
  logic [7:0] slot_live;

  assign row_lo = (r_col < 4'd8) ? 4'd0 : (r_col - 4'd7);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_gather
      assign row_idx[gi]   = row_lo + 4'(gi);
      assign col_idx[gi]   = r_col - row_idx[gi];
      assign slot_live[gi] = (row_idx[gi] <= 4'd7) && (row_idx[gi] <= r_col) &&
                             (col_idx[gi] <= 4'd7);
      assign col_bits[gi]  = slot_live[gi] & r_b[row_idx[gi][2:0]] & r_a[col_idx[gi][2:0]];
    end
  endgenerate

  logic       cmp_res;
  logic       cmp_cry;
  logic [5:0] cmp_cry6;

  mul_01bitx08_wallace u_cmp (
    .i_num       (col_bits),
    .i_cry_06bit (r_cry6),
    .o_res       (cmp_res),
    .o_cry       (cmp_cry),
    .o_cry_06bit (cmp_cry6)
  );

  // This is the 1-bit ripple final adder. The column sum, the previous
  // column's half-adder carry and the ripple carry all have weight k.
  logic res_bit;
  logic cp_next;
  assign res_bit = cmp_res ^ r_cry1 ^ r_cp;
  assign cp_next = (cmp_res & r_cry1) | (cmp_res & r_cp) | (r_cry1 & r_cp);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      r_a    <= '0;
      r_b    <= '0;
      r_col  <= '0;
      r_cry6 <= '0;
      r_cry1 <= 1'b0;
      r_cp   <= 1'b0;
      r_res  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            r_a    <= i_num_a;
            r_b    <= i_num_b;
            r_col  <= '0;
            r_cry6 <= '0;
            r_cry1 <= 1'b0;
            r_cp   <= 1'b0;
            r_res  <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_res[r_col] <= res_bit;
          r_cp         <= cp_next;
          r_cry6       <= cmp_cry6;
          r_cry1       <= cmp_cry;
          r_col        <= r_col + 4'd1;
          if (r_col == 4'd15) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready = (state == ST_IDLE);
  assign o_busy  = (state == ST_RUN);
  assign o_valid = (state == ST_DONE);
  assign o_res   = r_res;

endmodule

// File: tb/tb_mul_08bitx08_wallace_seq.sv
// ---------------------------------------------------------------------------
// tb_mul_08bitx08_wallace_seq
//
// Purpose: directed and randomised checking of the sequential 8x8 multiplier.
// Covers reset values, latency, back-pressure, back-to-back initiation and
// asynchronous mid-run reset. It ends with a random batch of operand pairs
// using random consumer stalls.
// ---------------------------------------------------------------------------
module tb_mul_08bitx08_wallace_seq;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_num_a;
  logic [7:0]  i_num_b;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_res;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mul_08bitx08_wallace_seq dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_num_a (i_num_a),
    .i_num_b (i_num_b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_res   (o_res),
    .o_busy  (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // This task is entered at a negedge. It drives the operands, waits for the
  // accept, follows RUN and stalls the consumer for 'stall' cycles in DONE.
  // It returns at the negedge after the output is accepted. When 'chain' is
  // set, the next operand pair is already being presented at that point.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] expv, input int stall, input bit pulse,
                        input bit chain, input logic [7:0] na, input logic [7:0] nb,
                        output int acc);
    int n;
    int lat;
    int busy_cnt;
    int ready_bad;
    i_valid = 1'b1;
    i_num_a = a;
    i_num_b = b;
    n = 0;
    while (!o_ready && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    check_eq({tag, "/ready_wait"}, {31'd0, o_ready}, 32'd1);
    @(negedge i_clk);
    acc = cyc;
    i_valid = pulse;
    if (pulse) begin
      i_num_a = ~a;
      i_num_b = ~b;
    end
    lat = 0;
    busy_cnt = 0;
    ready_bad = 0;
    while (!o_valid && lat < 40) begin
      if (o_busy) busy_cnt++;
      if (o_ready) ready_bad++;
      @(negedge i_clk);
      lat++;
      if (pulse) i_valid = ~i_valid;
    end
    check_eq({tag, "/latency"}, lat, 16);
    check_eq({tag, "/busy_cycles"}, busy_cnt, 16);
    check_eq({tag, "/ready_in_run"}, ready_bad, 0);
    check_eq({tag, "/final_carry"}, {25'd0, dut.r_cry6, dut.r_cry1}, 32'd0);
    check_eq({tag, "/final_cp"}, {31'd0, dut.r_cp}, 32'd0);
    if (stall > 0) i_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      check_eq({tag, "/stall_hold"}, {14'd0, o_valid, o_ready, o_res}, {14'd0, 1'b1, 1'b0, expv});
      @(negedge i_clk);
      if (pulse) i_valid = ~i_valid;
    end
    i_ready = 1'b1;
    check_eq({tag, "/res"}, {16'd0, o_res}, {16'd0, expv});
    check_eq({tag, "/valid"}, {31'd0, o_valid}, 32'd1);
    @(negedge i_clk);
    check_eq({tag, "/after_accept"}, {30'd0, o_ready, o_valid}, 32'd2);
    if (chain) begin
      i_valid = 1'b1;
      i_num_a = na;
      i_num_b = nb;
    end else begin
      i_valid = 1'b0;
    end
    $display("op %s a=0x%02h b=0x%02h res=0x%04h exp=0x%04h lat=%0d stall=%0d",
             tag, a, b, o_res, expv, lat, stall);
  endtask

  int acc1;
  int acc2;
  int dummy;
  logic [7:0] ra;
  logic [7:0] rb;
  int rs;

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_num_a = 8'h00;
    i_num_b = 8'h00;
    i_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    check_eq("reset/outs", {13'd0, o_ready, o_valid, o_busy, o_res}, {13'd0, 3'b100, 16'h0000});
    i_rst = 1'b0;
    @(negedge i_clk);
    check_eq("reset/after_release", {13'd0, o_ready, o_valid, o_busy, o_res}, {13'd0, 3'b100, 16'h0000});

    run_op("zero", 8'h00, 8'h00, 16'h0000, 0, 1'b0, 1'b0, 8'h00, 8'h00, dummy);
    run_op("ffxff", 8'hFF, 8'hFF, 16'hFE01, 0, 1'b0, 1'b0, 8'h00, 8'h00, dummy);

    run_op("b2b_1", 8'h0D, 8'h0B, 16'h008F, 0, 1'b0, 1'b1, 8'h12, 8'h34, acc1);
    run_op("b2b_2", 8'h12, 8'h34, 16'h03A8, 0, 1'b0, 1'b0, 8'h00, 8'h00, acc2);
    check_eq("b2b/initiation", acc2 - acc1, 18);

    run_op("bp", 8'hA5, 8'h3C, 16'h26AC, 5, 1'b1, 1'b0, 8'h00, 8'h00, dummy);

    // Apply an asynchronous reset between edges while column 7 is pending.
    i_valid = 1'b1;
    i_num_a = 8'h12;
    i_num_b = 8'h34;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (7) @(posedge i_clk);
    #2;
    check_eq("arst/col_before", {28'd0, dut.r_col}, 32'd7);
    check_eq("arst/partial_nonzero", {31'd0, (o_res != 16'h0000)}, 32'd1);
    i_rst = 1'b1;
    #1;
    check_eq("arst/outs", {14'd0, o_busy, o_valid, o_res}, 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check_eq("arst/ready", {31'd0, o_ready}, 32'd1);
    @(negedge i_clk);
    run_op("arst_next", 8'h12, 8'h34, 16'h03A8, 0, 1'b0, 1'b0, 8'h00, 8'h00, dummy);

    run_op("edge_80x02", 8'h80, 8'h02, 16'h0100, 1, 1'b0, 1'b0, 8'h00, 8'h00, dummy);
    run_op("edge_01xff", 8'h01, 8'hFF, 16'h00FF, 2, 1'b0, 1'b0, 8'h00, 8'h00, dummy);
    run_op("edge_ffx80", 8'hFF, 8'h80, 16'h7F80, 0, 1'b0, 1'b0, 8'h00, 8'h00, dummy);

    for (int k = 0; k < 1200; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = $urandom_range(0, 3);
      run_op("rand", ra, rb, 16'(ra) * 16'(rb), rs, 1'b0, 1'b0, 8'h00, 8'h00, dummy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
